// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO registers read back through out.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] out
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4,
    OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MADD = 4'd7, OP_MADDU = 4'd8,
    OP_MSUB = 4'd9, OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic { S_IDLE, S_RUN } state_e;
  typedef enum logic [1:0] { K_SET, K_ADD, K_SUB, K_KEEP } kind_e;

  state_e      state;
  logic [3:0]  cnt;
  logic [31:0] hi, lo;
  logic [63:0] pending;
  kind_e       pend_kind;

  op_e         op_d;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_safe, b_mag_safe;
  logic [31:0] qs_mag, rs_mag, quot_s, rem_s;
  logic [63:0] prod_s, prod_u;
  logic        launch;
  logic [3:0]  lat;
  logic [63:0] res;
  kind_e       kind;

  always_comb begin
    op_d = OP_NONE;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: op_d = op_e'(op);
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10:            op_d = op_e'(op);
`endif
      default:                            op_d = OP_NONE;
    endcase
  end

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
  always_comb begin
    a_neg      = A[31];
    b_neg      = B[31];
    b_zero     = (B == '0);
    a_mag      = a_neg ? (~A + 32'd1) : A;
    b_mag      = b_neg ? (~B + 32'd1) : B;
    b_safe     = b_zero ? 32'd1 : B;
    b_mag_safe = b_zero ? 32'd1 : b_mag;
    qs_mag     = a_mag / b_mag_safe;
    rs_mag     = a_mag % b_mag_safe;
    quot_s     = (a_neg ^ b_neg) ? (~qs_mag + 32'd1) : qs_mag;
    rem_s      = a_neg ? (~rs_mag + 32'd1) : rs_mag;
    prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u     = {32'd0, A} * {32'd0, B};
  end

  always_comb begin
    launch = 1'b0;
    lat    = 4'(MULT_CYCLES);
    res    = prod_s;
    kind   = K_SET;
    case (op_d)
      OP_MULT:  launch = 1'b1;
      OP_MULTU: begin launch = 1'b1; res = prod_u; end
      OP_DIV: begin
        launch = 1'b1;
        lat    = 4'(DIV_CYCLES);
        res    = {rem_s, quot_s};
        kind   = b_zero ? K_KEEP : K_SET;
      end
      OP_DIVU: begin
        launch = 1'b1;
        lat    = 4'(DIV_CYCLES);
        res    = {A % b_safe, A / b_safe};
        kind   = b_zero ? K_KEEP : K_SET;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin launch = 1'b1; kind = K_ADD; end
      OP_MADDU: begin launch = 1'b1; res = prod_u; kind = K_ADD; end
      OP_MSUB:  begin launch = 1'b1; kind = K_SUB; end
      OP_MSUBU: begin launch = 1'b1; res = prod_u; kind = K_SUB; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      pending   <= '0;
      pend_kind <= K_KEEP;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (launch) begin
              pending   <= res;
              pend_kind <= kind;
              cnt       <= lat;
              busy      <= 1'b1;
              state     <= S_RUN;
            end
            if (op_d == OP_MTHI) hi <= A;
            if (op_d == OP_MTLO) lo <= A;
          end
        end
        S_RUN: begin
          if (cnt == 4'd1) begin
            // Accumulate ops read HI/LO here, at commit, not at issue.
            case (pend_kind)
              K_SET: {hi, lo} <= pending;
`ifdef MDU_MADD_EN
              K_ADD: {hi, lo} <= {hi, lo} + pending;
              K_SUB: {hi, lo} <= {hi, lo} - pending;
`endif
              default: ;
            endcase
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out = rd_hi ? hi : lo;

endmodule
